// File: rtl/fcmp_pipe.sv
// fcmp_pipe: two-stage pipelined FP32 compare unit (FEQ / FLT / FLE).
//
// Sits between FPU issue and the integer writeback arbiter. It produces
// {31'b0, flag} tagged with the destination register. Both sides use
// valid/ready handshakes, and a branch-redirect flush kills all in-flight ops.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rstn       asynchronous active-low reset
//   flush      kill every in-flight op; takes effect on the next edge
//   in_valid   upstream op valid
//   in_ready   unit can accept an op this cycle
//   in_op      00=FEQ, 01=FLT, 10=FLE, 11=reserved (result 0)
//   in_x1      FP32 operand 1
//   in_x2      FP32 operand 2
//   in_tag     destination-register tag
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out_y      {31'b0, flag}
//   out_tag    tag of the result
//   busy       some stage holds a valid op
module fcmp_pipe #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_x1,
  input  logic [31:0]      in_x2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_y,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int DATA_W = 32;

  // Denormals, including both signed zeros, collapse to +0.
  // As a result, -0 == +0 and tiny values compare as zero.
  function automatic logic [DATA_W-1:0] ftz(input logic [DATA_W-1:0] x);
    return (x[30:23] == 8'h00) ? '0 : x;
  endfunction

  // Sign-magnitude ordering. With opposite signs, the negative operand is
  // the smaller one. With the same sign, magnitude order is inverted for
  // negatives. Equal patterns are never less-than.
  function automatic logic sel_flag(input logic [1:0] op,
                                    input logic       sgn_diff,
                                    input logic       a_sgn,
                                    input logic       mag_lt,
                                    input logic       eq);
    logic lt;
    lt = sgn_diff ? a_sgn : (eq ? 1'b0 : (a_sgn ^ mag_lt));
    case (op)
      2'b00:   return eq;
      2'b01:   return lt;
      2'b10:   return lt | eq;
      default: return 1'b0;
    endcase
  endfunction

  logic              vld_p1, vld_p2;
  logic              sgn_diff_p1, a_sgn_p1, mag_lt_p1, eq_p1;
  logic [1:0]        op_p1;
  logic [TAG_W-1:0]  tag_p1, tag_p2;
  logic              flag_p2;
  logic [DATA_W-1:0] a_p0, b_p0;
  logic              in_fire, s2_adv;

  assign s2_adv   = vld_p1 & (~vld_p2 | out_ready);
  assign in_ready = rstn & ~flush & (~vld_p1 | s2_adv);
  assign in_fire  = in_valid & in_ready;

  assign a_p0 = ftz(in_x1);
  assign b_p0 = ftz(in_x2);

  // Control: flush dominates accept and advance.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (in_fire)      vld_p1 <= 1'b1;
      else if (s2_adv)  vld_p1 <= 1'b0;
      if (s2_adv)         vld_p2 <= 1'b1;
      else if (out_ready) vld_p2 <= 1'b0;
    end
  end

  // ---- stage 0 -> 1: flush-to-zero operands, register compare flags ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sgn_diff_p1 <= 1'b0;
      a_sgn_p1    <= 1'b0;
      mag_lt_p1   <= 1'b0;
      eq_p1       <= 1'b0;
      op_p1       <= 2'b00;
      tag_p1      <= '0;
    end else if (in_fire) begin
      sgn_diff_p1 <= a_p0[31] ^ b_p0[31];
      a_sgn_p1    <= a_p0[31];
      mag_lt_p1   <= a_p0[30:0] < b_p0[30:0];
      eq_p1       <= a_p0 == b_p0;
      op_p1       <= in_op;
      tag_p1      <= in_tag;
    end
  end

  // ---- stage 1 -> 2: select the flag for the requested op ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      flag_p2 <= 1'b0;
      tag_p2  <= '0;
    end else if (s2_adv) begin
      flag_p2 <= sel_flag(op_p1, sgn_diff_p1, a_sgn_p1, mag_lt_p1, eq_p1);
      tag_p2  <= tag_p1;
    end
  end

  assign out_valid = vld_p2;
  assign out_y     = {31'b0, flag_p2};
  assign out_tag   = tag_p2;
  assign busy      = vld_p1 | vld_p2;

endmodule

// File: tb/tb_fcmp_pipe.sv
// Self-checking bench for fcmp_pipe. The bench drives inputs one time unit
// after each rising edge and samples outputs on the falling edge. Expected
// {tag, flag} entries are queued on every accept and popped on every
// output transfer.
module tb_fcmp_pipe;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rstn, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [1:0]       in_op;
  logic [31:0]      in_x1, in_x2, out_y;
  logic [TAG_W-1:0] in_tag, out_tag;

  logic [TAG_W:0]   exp_q[$];
  int               n_chk = 0;
  int               n_fail = 0;

  fcmp_pipe #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_x1(in_x1), .in_x2(in_x2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Reference: order the flushed operands as signed integers keyed by sign-magnitude.
  function automatic logic model_flag(input logic [1:0] op, input logic [31:0] x1, input logic [31:0] x2);
    logic [31:0] a, b;
    longint ka, kb;
    logic lt, eq;
    a  = (x1[30:23] == 8'h00) ? 32'h0 : x1;
    b  = (x2[30:23] == 8'h00) ? 32'h0 : x2;
    ka = a[31] ? -longint'(a[30:0]) : longint'(a[30:0]);
    kb = b[31] ? -longint'(b[30:0]) : longint'(b[30:0]);
    eq = (a == b);
    lt = (ka < kb);
    case (op)
      2'b00:   return eq;
      2'b01:   return lt;
      2'b10:   return lt | eq;
      default: return 1'b0;
    endcase
  endfunction

  task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] x1,
                       input logic [31:0] x2, input logic [TAG_W-1:0] tag);
    in_valid = v; in_op = op; in_x1 = x1; in_x2 = x2; in_tag = tag;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(1'b1, 2'b00, 32'h3F800000, 32'h3F800000, 5'd0);
    #3;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_chk++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_chk++; if (out_y !== 32'h0)    begin n_fail++; $display("FAIL reset_out_y got=%h exp=0", out_y); end
    n_chk++; if (out_tag !== '0)     begin n_fail++; $display("FAIL reset_out_tag got=%h exp=0", out_tag); end
    n_chk++; if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
    @(negedge clk); rstn = 1'b1;
    next_cycle();
  endtask

  // Directed vectors, each issued alone, with exact 2-cycle latency check.
  task automatic test_compare();
    logic [1:0]  ops[10] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b10};
    logic [31:0] xa[10]  = '{32'h3F800000, 32'h80000000, 32'hBF800000, 32'h40000000, 32'hC0000000,
                             32'hBF800000, 32'hBF800000, 32'h3F800000, 32'h3F800000, 32'h80000001};
    logic [31:0] xb[10]  = '{32'h3F800000, 32'h00000001, 32'h3F800000, 32'h3F800000, 32'hBF800000,
                             32'hBF800000, 32'hBF800000, 32'h00000000, 32'h3F800000, 32'h00000000};
    logic [TAG_W:0] e;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, ops[i], xa[i], xb[i], TAG_W'(i + 3));
      @(negedge clk);
      n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL cmp_in_ready[%0d] got=%b exp=1", i, in_ready); end
      if (in_valid && in_ready) exp_q.push_back({in_tag, model_flag(ops[i], xa[i], xb[i])});
      next_cycle();
      drive(1'b0, 2'b00, 32'h0, 32'h0, '0);
      @(negedge clk);
      n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL cmp_early_valid[%0d] got=%b exp=0", i, out_valid); end
      next_cycle();
      @(negedge clk);
      n_chk++;
      if (out_valid !== 1'b1 || exp_q.size() == 0) begin
        n_fail++; $display("FAIL cmp_latency[%0d] out_valid=%b exp=1", i, out_valid);
      end else begin
        e = exp_q.pop_front();
        if (out_y !== {31'b0, e[0]} || out_tag !== e[TAG_W:1]) begin
          n_fail++; $display("FAIL cmp_result[%0d] got y=%h tag=%0d exp y=%h tag=%0d",
                             i, out_y, out_tag, {31'b0, e[0]}, e[TAG_W:1]);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    logic [TAG_W:0] e;
    logic [31:0] x1, x2;
    int issued = 0;
    logic [TAG_W-1:0] t = '0;
    for (int c = 0; c < 400; c++) begin
      if (issued >= 60 && exp_q.size() == 0 && !busy) break;
      x1 = $urandom;
      x2 = ($urandom_range(0, 3) == 0) ? x1 : $urandom;
      if ($urandom_range(0, 4) == 0) x1[30:23] = 8'h00;
      if ($urandom_range(0, 2) == 0) x2[31] = x1[31];
      drive(issued < 60 && $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), x1, x2, t);
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (out_valid && out_ready) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL b2b_spurious got tag=%0d exp none", out_tag);
        end else begin
          e = exp_q.pop_front();
          if (out_y !== {31'b0, e[0]} || out_tag !== e[TAG_W:1]) begin
            n_fail++; $display("FAIL b2b_result got y=%h tag=%0d exp y=%h tag=%0d",
                               out_y, out_tag, {31'b0, e[0]}, e[TAG_W:1]);
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({in_tag, model_flag(in_op, in_x1, in_x2)});
        issued++; t++;
      end
      next_cycle();
    end
    drive(1'b0, 2'b00, 32'h0, 32'h0, '0);
    n_chk++; if (exp_q.size() != 0 || issued != 60) begin
      n_fail++; $display("FAIL b2b_drain got pending=%0d issued=%0d exp pending=0 issued=60", exp_q.size(), issued);
    end
  endtask

  task automatic test_backpressure();
    logic [1:0]  ops[4] = '{2'b01, 2'b00, 2'b10, 2'b01};
    logic [31:0] xa[4]  = '{32'hBF800000, 32'h3F800000, 32'h3F800000, 32'h40000000};
    logic [31:0] xb[4]  = '{32'h3F800000, 32'h40000000, 32'h3F800000, 32'h3F800000};
    logic [TAG_W:0] e;
    logic [31:0] hold_y;
    logic [TAG_W-1:0] hold_tag;
    int idx = 0, nout = 0, first_c = -1, last_c = -1;
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (idx < 4) drive(1'b1, ops[idx], xa[idx], xb[idx], TAG_W'(idx + 1));
      else drive(1'b0, 2'b00, 32'h0, 32'h0, '0);
      @(negedge clk);
      if (c == 2) begin hold_y = out_y; hold_tag = out_tag; end
      if (c > 2) begin
        n_chk++; if (out_valid !== 1'b1 || out_y !== hold_y || out_tag !== hold_tag) begin
          n_fail++; $display("FAIL bp_stable got v=%b y=%h tag=%0d exp v=1 y=%h tag=%0d",
                             out_valid, out_y, out_tag, hold_y, hold_tag);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({in_tag, model_flag(ops[idx], xa[idx], xb[idx])});
        idx++;
      end
      next_cycle();
    end
    n_chk++; if (idx != 2) begin n_fail++; $display("FAIL bp_accepts got=%0d exp=2", idx); end
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (idx < 4) drive(1'b1, ops[idx], xa[idx], xb[idx], TAG_W'(idx + 1));
      else drive(1'b0, 2'b00, 32'h0, 32'h0, '0);
      @(negedge clk);
      if (out_valid && out_ready) begin
        n_chk++;
        if (first_c < 0) first_c = c;
        last_c = c;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL bp_extra got tag=%0d exp none", out_tag);
        end else begin
          e = exp_q.pop_front();
          if (out_tag !== TAG_W'(nout + 1) || out_y !== {31'b0, e[0]} || out_tag !== e[TAG_W:1]) begin
            n_fail++; $display("FAIL bp_order got y=%h tag=%0d exp y=%h tag=%0d",
                               out_y, out_tag, {31'b0, e[0]}, nout + 1);
          end
        end
        nout++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({in_tag, model_flag(ops[idx], xa[idx], xb[idx])});
        idx++;
      end
      next_cycle();
    end
    n_chk++; if (nout != 4 || last_c - first_c != 3) begin
      n_fail++; $display("FAIL bp_count got outputs=%0d span=%0d exp outputs=4 span=3", nout, last_c - first_c);
    end
  endtask

  task automatic test_flush();
    logic [TAG_W:0] e;
    int acc = 0, seen = 0, lat = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 6 && acc < 2; c++) begin
      drive(1'b1, 2'b00, 32'h3F800000, 32'h3F800000, TAG_W'(20 + acc));
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      next_cycle();
    end
    flush = 1'b1; out_ready = 1'b1;
    drive(1'b1, 2'b00, 32'h3F800000, 32'h3F800000, 5'd9);
    @(negedge clk);
    n_chk++; if (in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL flush_cycle got in_ready=%b busy=%b out_valid=%b exp 0 1 1", in_ready, busy, out_valid);
    end
    next_cycle();
    flush = 1'b0;
    exp_q.delete();
    drive(1'b1, 2'b01, 32'hBF800000, 32'h3F800000, 5'd10);
    @(negedge clk);
    n_chk++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL flush_clear got out_valid=%b busy=%b exp 0 0", out_valid, busy);
    end
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_after_ready got=%b exp=1", in_ready); end
    if (in_valid && in_ready) exp_q.push_back({in_tag, model_flag(in_op, in_x1, in_x2)});
    next_cycle();
    drive(1'b0, 2'b00, 32'h0, 32'h0, '0);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (out_valid) begin
        seen++; lat = c;
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL flush_extra got tag=%0d exp none", out_tag);
        end else begin
          e = exp_q.pop_front();
          if (out_y !== {31'b0, e[0]} || out_tag !== e[TAG_W:1]) begin
            n_fail++; $display("FAIL flush_result got y=%h tag=%0d exp y=%h tag=%0d",
                               out_y, out_tag, {31'b0, e[0]}, e[TAG_W:1]);
          end
        end
      end
      next_cycle();
    end
    n_chk++; if (seen != 1 || lat != 2) begin
      n_fail++; $display("FAIL flush_followup got results=%0d cycle=%0d exp results=1 cycle=2", seen, lat);
    end
  endtask

  task automatic test_async_reset();
    logic [TAG_W:0] e;
    int acc = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 6 && acc < 2; c++) begin
      drive(1'b1, 2'b10, 32'hBF800000, 32'hBF800000, TAG_W'(12 + acc));
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      next_cycle();
    end
    drive(1'b0, 2'b00, 32'h0, 32'h0, '0);
    #2;
    n_chk++; if (out_valid !== 1'b1 || out_y !== 32'h1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL arst_pre got v=%b y=%h busy=%b exp 1 1 1", out_valid, out_y, busy);
    end
    rstn = 1'b0;
    #1;
    n_chk++; if (out_valid !== 1'b0 || busy !== 1'b0 || out_y !== 32'h0 || out_tag !== '0 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL arst_immediate got v=%b busy=%b y=%h tag=%0d rdy=%b exp all 0",
                         out_valid, busy, out_y, out_tag, in_ready);
    end
    exp_q.delete();
    @(negedge clk); rstn = 1'b1;
    next_cycle();
    out_ready = 1'b1;
    drive(1'b1, 2'b01, 32'hC0000000, 32'hBF800000, 5'd7);
    @(negedge clk);
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL arst_ready got=%b exp=1", in_ready); end
    if (in_valid && in_ready) exp_q.push_back({in_tag, model_flag(in_op, in_x1, in_x2)});
    next_cycle();
    drive(1'b0, 2'b00, 32'h0, 32'h0, '0);
    @(negedge clk);
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_early got=%b exp=0", out_valid); end
    next_cycle();
    @(negedge clk);
    n_chk++;
    if (out_valid !== 1'b1 || exp_q.size() == 0) begin
      n_fail++; $display("FAIL arst_latency got out_valid=%b exp=1", out_valid);
    end else begin
      e = exp_q.pop_front();
      if (out_y !== {31'b0, e[0]} || out_tag !== e[TAG_W:1]) begin
        n_fail++; $display("FAIL arst_result got y=%h tag=%0d exp y=%h tag=%0d",
                           out_y, out_tag, {31'b0, e[0]}, e[TAG_W:1]);
      end
    end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_compare();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
